// File: rtl/nios_system_sram_copy_master_pkg.sv
// Shared definitions for the SRAM copy master: SRAM geometry and FSM state encodings.
package nios_system_sram_copy_master_pkg;

  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } copy_state_e;

  // States in which a copy is in progress and abort is honoured.
  function automatic logic is_active(copy_state_e s);
    return (s == ST_READ) || (s == ST_WAIT) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/nios_system_sram_copy_master_ptr.sv
// Loadable word-address counter; increments modulo 2^ADDR_W so it wraps 2047 -> 0.
module nios_system_sram_copy_master_ptr #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] value
);

  logic [ADDR_W-1:0] value_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (inc) begin
      value_reg <= value_reg + 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/nios_system_sram_copy_master.sv
// Avalon-MM copy engine: forward-copies word_count words inside the SRAM via READ/WAIT/WRITE
// cycles and accumulates an additive checksum of the words written.
module nios_system_sram_copy_master
  import nios_system_sram_copy_master_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_COUNT = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);

  copy_state_e       state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] checksum_reg;
  logic              aborted_reg;

  logic [ADDR_W:0]   count_clamped;
  logic              accept_start, take_abort, last_wait, write_fire, last_word;
  logic [ADDR_W-1:0] ptr_init  [2];
  logic [ADDR_W-1:0] ptr_value [2];

  assign count_clamped = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
  assign accept_start  = (state_reg == ST_IDLE) && start;
  assign take_abort    = is_active(state_reg) && abort;
  assign last_wait     = (state_reg == ST_WAIT) && (wait_cnt_reg == '0);
  assign write_fire    = (state_reg == ST_WRITE);
  assign last_word     = write_fire && (remaining_reg == ONE_COUNT);

  // Index 0 is the source pointer, index 1 the destination pointer.
  assign ptr_init[0] = src_addr;
  assign ptr_init[1] = dst_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ptr
      nios_system_sram_copy_master_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept_start),
        .inc        (write_fire),
        .load_value (ptr_init[gi]),
        .value      (ptr_value[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (count_clamped == '0) ? ST_DONE : ST_READ;
      ST_READ:  state_next = ST_WAIT;
      ST_WAIT:  if (last_wait) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_DONE : ST_READ;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (take_abort) state_next = ST_DONE;
  end

  always_comb begin
    busy           = is_active(state_reg);
    done           = (state_reg == ST_DONE);
    mem_chipselect = (state_reg == ST_READ) || (state_reg == ST_WRITE);
    mem_write      = (state_reg == ST_WRITE);
    mem_address    = '0;
    if (state_reg == ST_READ)  mem_address = ptr_value[0];
    if (state_reg == ST_WRITE) mem_address = ptr_value[1];
  end

  // The word presented during an aborted WRITE still reaches the SRAM, so it is counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg  <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      checksum_reg  <= '0;
      aborted_reg   <= 1'b0;
    end else begin
      if (accept_start) begin
        remaining_reg <= count_clamped;
        checksum_reg  <= '0;
        aborted_reg   <= 1'b0;
      end
      if (state_reg == ST_READ) wait_cnt_reg <= WAIT_LOAD;
      if ((state_reg == ST_WAIT) && !last_wait) wait_cnt_reg <= wait_cnt_reg - 1'b1;
      if (last_wait && !abort) data_reg <= mem_readdata;
      if (write_fire) begin
        checksum_reg  <= checksum_reg + data_reg;
        remaining_reg <= remaining_reg - ONE_COUNT;
      end
      if (take_abort) aborted_reg <= 1'b1;
    end
  end

  assign aborted        = aborted_reg;
  assign checksum       = checksum_reg;
  assign mem_writedata  = data_reg;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_nios_system_sram_copy_master.sv
// Bench for the SRAM copy master: SRAM model with one-cycle read latency, and a word-level
// reference copy model that predicts memory contents, checksum and done timing.
module tb_nios_system_sram_copy_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] src_addr = '0;
  logic [10:0] dst_addr = '0;
  logic [11:0] word_count = '0;
  logic        busy, done, aborted;
  logic [31:0] checksum;
  logic [10:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] mem     [2048];
  logic [31:0] exp_mem [2048];
  logic [31:0] rd_data = '0;
  int          wr_count = 0;
  int          cs_count = 0;

  int n_checks = 0;
  int n_errors = 0;

  nios_system_sram_copy_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .word_count     (word_count),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .checksum       (checksum),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_clken      (mem_clken)
  );

  always #5 clk = ~clk;

  // SRAM: registered read data gives a read latency of one cycle.
  always @(posedge clk) begin
    if (mem_chipselect && mem_write) begin
      mem[mem_address] <= mem_writedata;
      wr_count <= wr_count + 1;
    end
    if (mem_chipselect && !mem_write) rd_data <= mem[mem_address];
    if (mem_chipselect) cs_count <= cs_count + 1;
  end
  assign mem_readdata = rd_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One copy transaction. abort_w: abort during that WRITE (1-based, 0 = none).
  // restart: issue a second start mid-copy. reset_at: pull reset_n low in that cycle (0 = none).
  task automatic run_copy(input string name, input int src, input int dst, input int cnt,
                          input int abort_w, input bit restart, input int reset_at);
    int n_words, words_done, exp_done_cyc, abort_cyc, done_cyc, pulses, busy_err, limit;
    int wr0, cs0, bad_words, ai, di;
    bit exp_ab, was_reset;
    logic [31:0] exp_sum;

    n_words      = (cnt > 2048) ? 2048 : cnt;
    words_done   = n_words;
    exp_ab       = 1'b0;
    exp_done_cyc = 1 + 3 * n_words;
    abort_cyc    = 0;
    if (abort_w > 0 && abort_w <= n_words) begin
      words_done   = abort_w;
      exp_ab       = 1'b1;
      exp_done_cyc = 3 * abort_w + 1;
      abort_cyc    = 3 * abort_w;
    end
    if (reset_at > 0) words_done = (reset_at - 1) / 3;

    exp_sum = '0;
    for (int i = 0; i < words_done; i++) begin
      ai = (src + i) % 2048;
      di = (dst + i) % 2048;
      exp_mem[di] = exp_mem[ai];
      exp_sum += exp_mem[ai];
    end

    @(negedge clk);
    src_addr   = 11'(src);
    dst_addr   = 11'(dst);
    word_count = 12'(cnt);
    start      = 1'b1;
    wr0 = wr_count;
    cs0 = cs_count;
    @(posedge clk);
    #1 start = 1'b0;

    done_cyc = 0; pulses = 0; busy_err = 0; was_reset = 1'b0;
    limit = exp_done_cyc + 4;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (reset_at == n) begin
        reset_n = 1'b0;
        #1;
        chk({name, " rst busy"}, 32'(busy), 32'd0);
        chk({name, " rst cs"}, 32'(mem_chipselect), 32'd0);
        chk({name, " rst wr"}, 32'(mem_write), 32'd0);
        chk({name, " rst sum"}, checksum, 32'd0);
        chk({name, " rst addr"}, 32'(mem_address), 32'd0);
        chk({name, " rst wdata"}, mem_writedata, 32'd0);
        chk({name, " rst done"}, 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        chk({name, " rst no-access"}, 32'(cs_count - cs0), 32'(((reset_at - 1) / 3) + ((reset_at + 1) / 3)));
        reset_n = 1'b1;
        was_reset = 1'b1;
        break;
      end
      abort = (n == abort_cyc);
      if (restart && n == 2) begin
        start = 1'b1; src_addr = 11'h3AA; dst_addr = 11'h155; word_count = 12'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        pulses++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (busy !== (n < exp_done_cyc)) busy_err++;
    end
    abort = 1'b0;
    start = 1'b0;

    bad_words = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== exp_mem[i]) bad_words++;
    chk({name, " mem"}, 32'(bad_words), 32'd0);
    chk({name, " writes"}, 32'(wr_count - wr0), 32'(words_done));
    if (!was_reset) begin
      chk({name, " done cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
      chk({name, " done pulses"}, 32'(pulses), 32'd1);
      chk({name, " busy"}, 32'(busy_err), 32'd0);
      chk({name, " checksum"}, checksum, exp_sum);
      chk({name, " aborted"}, 32'(aborted), 32'(exp_ab));
      chk({name, " accesses"}, 32'(cs_count - cs0), 32'(2 * words_done));
    end
    $display("copy %s src=%h dst=%h cnt=%0d words=%0d sum=%h done@%0d reset=%0d",
             name, 11'(src), 11'(dst), cnt, words_done, checksum, done_cyc, was_reset);
  endtask

  initial begin
    int s, d, c, a;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 32'(i + 32'h100);
      exp_mem[i] = 32'(i + 32'h100);
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset cs", 32'(mem_chipselect), 32'd0);
    chk("reset sum", checksum, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken", 32'(mem_clken), 32'd1);
    chk("byteenable", 32'(mem_byteenable), 32'hF);

    run_copy("T1 basic", 'h10, 'h80, 4, 0, 1'b0, 0);
    chk("T1 sum const", checksum, 32'h446);
    run_copy("T2 zero", 'h20, 'h40, 0, 0, 1'b0, 0);
    run_copy("T3 wrap", 'h7FE, 'h000, 3, 0, 1'b0, 0);
    run_copy("T4 abort", 'h100, 'h200, 8, 2, 1'b0, 0);
    run_copy("T5 restart", 'h300, 'h340, 5, 0, 1'b1, 0);
    run_copy("T6 reset", 'h400, 'h500, 6, 0, 1'b0, 5);

    // Abort in IDLE must not produce a done pulse or set aborted.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle abort done", 32'(done), 32'd0);
    chk("idle abort flag", 32'(aborted), 32'd0);

    for (int t = 0; t < 10; t++) begin
      s = $urandom_range(0, 2047);
      d = $urandom_range(0, 2047);
      c = $urandom_range(0, 24);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, c + 1) : 0;
      run_copy($sformatf("R%0d", t), s, d, c, a, 1'b0, 0);
    end
    run_copy("clamp", 'h005, 'h400, 3000, 0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
